// File: rtl/pc_reg.sv
// pc_reg: program counter register for the RISC-V core.
//
// Holds the address of the instruction currently being fetched. On every
// rising clock edge out of reset the next-PC value from the fetch/branch
// logic is loaded, unless the pipeline asserts a stall, in which case the
// current PC is held. The register is a pure pass-through: no increment and
// no wrap logic live here.
//
// Optional build macro:
//   PC_ALIGN_CHECK_EN - adds the registered O_misaligned flag, set when a
//                       loaded address is not 4-byte aligned. The PC itself
//                       still loads the unmodified address; trapping on the
//                       flag is left to the trap logic.
//
// Ports:
//   I_clk        in   1      system clock, rising edge active
//   I_rst        in   1      asynchronous reset, active-low (0 = in reset)
//   I_stall      in   1      1 = hold current PC, 0 = load I_address
//   I_address    in   WIDTH  next-PC value from fetch/branch logic
//   O_misaligned out  1      alignment fault flag (PC_ALIGN_CHECK_EN only)
//   O_address    out  WIDTH  current PC, registered
//
// Parameters:
//   WIDTH        address path width (at least 2 for the alignment check)
//   RESET_ADDR   boot address driven while I_rst is low

module pc_reg #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(32'h0000_0000)
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_stall,
    input  logic [WIDTH-1:0] I_address,
`ifdef PC_ALIGN_CHECK_EN
    output logic             O_misaligned,
`endif
    output logic [WIDTH-1:0] O_address
);

    // Load enable: a stall simply suppresses the update.
    logic load_c;

    assign load_c = ~I_stall;

    // PC register; the async reset dominates any concurrent clock edge or
    // stall, so the boot address is visible immediately on reset assertion.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            O_address <= RESET_ADDR;
        end else if (load_c) begin
            O_address <= I_address;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Alignment flag tracks the address it was computed from, so it is
    // updated on the same loading edges and holds across stalls.
    logic misaligned_c;

    assign misaligned_c = (I_address[1:0] != 2'b00);

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            O_misaligned <= 1'b0;
        end else if (load_c) begin
            O_misaligned <= misaligned_c;
        end
    end
`endif

endmodule

// File: tb/tb_pc_reg.sv
// tb_pc_reg: self-checking bench for pc_reg.
//
// Expected PC (and alignment flag when PC_ALIGN_CHECK_EN is defined) is
// pushed to a scoreboard queue whenever stimulus is driven and popped and
// compared one clock later, after the DUT has registered it. Asynchronous
// reset behaviour is checked directly between clock edges.

module tb_pc_reg;

    localparam int unsigned      WIDTH    = 32;
    localparam logic [WIDTH-1:0] BOOT_PC  = 32'h0000_0000;

    typedef struct {
        logic [WIDTH-1:0] addr;
        logic             mis;
    } exp_t;

    logic             I_clk;
    logic             I_rst;
    logic             I_stall;
    logic [WIDTH-1:0] I_address;
    logic [WIDTH-1:0] O_address;
`ifdef PC_ALIGN_CHECK_EN
    logic             O_misaligned;
`endif

    exp_t             sb[$];
    logic [WIDTH-1:0] model_addr;
    logic             model_mis;
    int               n_checks;
    int               n_pass;

    pc_reg #(
        .WIDTH      (WIDTH),
        .RESET_ADDR (BOOT_PC)
    ) dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_stall      (I_stall),
        .I_address    (I_address),
`ifdef PC_ALIGN_CHECK_EN
        .O_misaligned (O_misaligned),
`endif
        .O_address    (O_address)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Pop the oldest expectation and compare it to the DUT outputs.
    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, WIDTH'(1), WIDTH'(0));
        end else begin
            e = sb.pop_front();
            check({tag, "_addr"}, O_address, e.addr);
`ifdef PC_ALIGN_CHECK_EN
            check({tag, "_mis"}, WIDTH'(O_misaligned), WIDTH'(e.mis));
`endif
        end
    endtask

    // Check the reset values of all outputs right now.
    task automatic check_reset(input string tag);
        check({tag, "_addr"}, O_address, BOOT_PC);
`ifdef PC_ALIGN_CHECK_EN
        check({tag, "_mis"}, WIDTH'(O_misaligned), WIDTH'(0));
`endif
    endtask

    task automatic model_reset();
        model_addr = BOOT_PC;
        model_mis  = 1'b0;
    endtask

    // Drive one cycle of stimulus at the falling edge, record the expected
    // outcome, then compare just after the next rising edge.
    task automatic step(input string tag, input logic stall,
                        input logic [WIDTH-1:0] addr);
        @(negedge I_clk);
        I_stall   = stall;
        I_address = addr;
        if (!stall) begin
            model_addr = addr;
            model_mis  = (addr[1:0] != 2'b00);
        end
        sb.push_back('{addr: model_addr, mis: model_mis});
        @(posedge I_clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        I_rst     = 1'b1;
        I_stall   = 1'b0;
        I_address = 32'hFFFF_FFFF;
        model_reset();

        // Power-up reset with the clock running and all-ones on the input.
        #1 I_rst = 1'b0;
        #1 check_reset("por_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge I_clk);
            #1 check_reset("por_edge");
        end

        // Release: nothing changes until the next rising edge.
        @(negedge I_clk);
        I_rst     = 1'b1;
        I_stall   = 1'b0;
        I_address = 32'h0000_0004;
        #1 check("release_pre_edge", O_address, BOOT_PC);
        model_addr = 32'h0000_0004;
        model_mis  = 1'b0;
        sb.push_back('{addr: model_addr, mis: model_mis});
        @(posedge I_clk);
        #1 compare_out("release_load");

        // Full-range pass-through on consecutive edges.
        step("all_ones", 1'b0, 32'hFFFF_FFFF);
        step("all_zero", 1'b0, 32'h0000_0000);

        // Stall holds for three edges, then the pending address loads.
        step("pre_stall", 1'b0, 32'h0000_0008);
        for (int i = 0; i < 3; i++) step("stall", 1'b1, 32'h0000_000C);
        step("unstall", 1'b0, 32'h0000_000C);

        // Asynchronous reset between edges, no stall.
        step("pre_rst", 1'b0, 32'h0000_0010);
        #2 I_rst = 1'b0;
        model_reset();
        #1 check_reset("async_rst");
        @(negedge I_clk);
        I_stall   = 1'b0;
        I_address = 32'h0000_AAAA;
        @(posedge I_clk);
        #1 check_reset("rst_ignores_load");

        // Asynchronous reset between edges while stalled.
        @(negedge I_clk);
        I_rst = 1'b1;
        step("pre_rst_stall", 1'b0, 32'h0000_0010);
        @(negedge I_clk);
        I_stall = 1'b1;
        #2 I_rst = 1'b0;
        model_reset();
        #1 check_reset("async_rst_stall");

        // Alignment flag sequence (PC checked in both builds).
        @(negedge I_clk);
        I_rst   = 1'b1;
        I_stall = 1'b0;
        step("load_6", 1'b0, 32'h0000_0006);
        step("load_8", 1'b0, 32'h0000_0008);
        step("load_3", 1'b0, 32'h0000_0003);
        step("stall_mis_hold", 1'b1, 32'h0000_0008);
        #2 I_rst = 1'b0;
        model_reset();
        #1 check_reset("mis_rst");

        // Reset asserted coincident with a loading edge: reset wins.
        @(negedge I_clk);
        I_rst = 1'b1;
        step("pre_coincident", 1'b0, 32'h0000_0020);
        @(negedge I_clk);
        I_stall   = 1'b0;
        I_address = 32'h0000_0055;
        @(posedge I_clk);
        I_rst = 1'b0;
        model_reset();
        #1 check_reset("coincident_rst");

        check("sb_drain", WIDTH'(sb.size()), WIDTH'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_reg.md
Name: pc_reg

Overview:
- Program counter register for the RISC-V CPU core. Holds the address of the instruction currently being fetched.
- Loads the next-PC value computed by the fetch/branch logic on every enabled clock edge. Drives that value to instruction memory and the rest of the pipeline.
- Supports an external stall that holds the current value.
- Resets asynchronously to a fixed boot address.

Parameters:
- WIDTH, 32, bit width of the address path.
- RESET_ADDR, 32'h00000000, value O_address takes while reset is asserted.

Ports:
- I_clk  input  1  system clock; all state updates on the rising edge.
- I_rst  input  1  reset, asynchronous, active-low (0 = in reset).
- I_stall  input  1  1 = hold the current PC; 0 = load I_address.
- I_address  input  WIDTH  next-PC value from the fetch/branch logic.
- O_address  output  WIDTH  current PC, registered.
- O_misaligned  output  1  alignment fault flag; present only with PC_ALIGN_CHECK_EN, see Optional Feature.

Behaviour:
- Reset
  - While I_rst = 0: O_address = RESET_ADDR, independent of the clock.
  - Takes effect immediately on the falling edge of I_rst, including mid-operation.
  - I_stall and I_address are ignored during reset.
- Reset release
  - Deassertion (I_rst 0->1) does not itself change O_address.
  - The first rising I_clk edge with I_rst = 1 performs the normal update.
- Normal update, at each rising I_clk edge with I_rst = 1:
  - I_stall = 0: O_address <= I_address.
  - I_stall = 1: O_address unchanged.
- Latency
  - Exactly one clock from I_address to O_address.
  - No combinational path from any input to O_address, except the asynchronous reset.
- Width and arithmetic
  - Pure register. No increment, no arithmetic inside the block.
  - Values pass through unmodified across the full WIDTH range, including 32'hFFFFFFFF and 32'h00000000. No wrap logic.
- Simultaneous events
  - Reset asserted coincident with a clock edge: reset wins, O_address = RESET_ADDR.
  - Stall and reset both active: reset wins.
- Unknown inputs
  - X/Z on I_stall while out of reset is not defined. Upstream must drive it.
  - The register itself holds no X after the first reset.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output O_misaligned (1 bit, registered).
  - On each loading edge (I_rst = 1, I_stall = 0): O_misaligned <= (I_address[1:0] != 2'b00).
  - O_address still loads the full I_address unmodified. Fault handling is the trap logic's job.
  - O_misaligned holds its value during a stall.
  - O_misaligned resets asynchronously to 0 with I_rst = 0.
- Not defined:
  - Port O_misaligned is absent.
  - No alignment logic is synthesized.
  - Behaviour of O_address is identical in both builds.

Test Plan:
- Reset from power-up: I_rst = 0, I_address = 32'hFFFFFFFF, clock running -> O_address = 32'h00000000 throughout, independent of clock edges.
- Release and load: raise I_rst = 1, I_stall = 0, I_address = 32'h00000004 -> O_address = 32'h00000004 after the next rising edge, not before.
- Full-range pass-through: load 32'hFFFFFFFF, then 32'h00000000 on consecutive edges -> O_address follows each value exactly one cycle later.
- Stall: O_address = 32'h00000008, set I_stall = 1 and I_address = 32'h0000000C for 3 edges -> O_address stays 32'h00000008. Drop I_stall -> 32'h0000000C after the next edge.
- Asynchronous reset mid-operation: O_address = 32'h00000010, pull I_rst = 0 between clock edges -> O_address = 32'h00000000 immediately. Also repeat with I_stall = 1.
- With PC_ALIGN_CHECK_EN:
  - Load 32'h00000006 -> O_address = 32'h00000006 and O_misaligned = 1 after the edge.
  - Then load 32'h00000008 -> O_misaligned = 0.
  - Then assert reset -> O_misaligned = 0.
